// File: rtl/peb_psum_router_pkg.sv
// Shared parameters, helper function and ping-pong FSM encoding for the PEB psum router.
package peb_psum_router_pkg;

`ifndef LENPSUM
`define LENPSUM 8
`endif

    // Ceiling log2 with a floor of 1, so a single-entry memory still gets a 1-bit address.
    function automatic int c_log_2(input int value);
        int r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DATA_WIDTH     = 8;
    localparam int BLOCK_DEPTH    = 8;
    localparam int DEF_LENPSUM    = `LENPSUM;
    localparam int DEF_PSUM_WIDTH = DATA_WIDTH * 2 + c_log_2(BLOCK_DEPTH) + 2;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_WAIT = 1'b1
    } pp_state_e;

endpackage

// File: rtl/peb_pingpong_ctrl.sv
// Output-bank ping-pong controller: bank select, pool ownership, array stall and sticky error.
module peb_pingpong_ctrl
    import peb_psum_router_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic fnh_frm,
    input  logic done,
    output logic bank_sel,
    output logic pool_busy,
    output logic stall,
    output logic err
);
    pp_state_e state, state_nxt;
    logic      bank_sel_nxt, pool_busy_nxt, err_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            bank_sel  <= 1'b0;
            pool_busy <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            bank_sel  <= bank_sel_nxt;
            pool_busy <= pool_busy_nxt;
            err       <= err_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        bank_sel_nxt  = bank_sel;
        pool_busy_nxt = pool_busy;
        err_nxt       = err;
        case (state)
            ST_ACC: begin
                if (fnh_frm && (!pool_busy || done)) begin
                    bank_sel_nxt  = ~bank_sel;
                    pool_busy_nxt = 1'b1;
                end else if (fnh_frm) begin
                    state_nxt = ST_WAIT;
                end else if (done) begin
                    pool_busy_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                // Pool releases the drain bank: the held frame swaps in and the pool stays busy with it.
                if (done) begin
                    bank_sel_nxt = ~bank_sel;
                    state_nxt    = ST_ACC;
                end
                if (fnh_frm) err_nxt = 1'b1;
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    assign stall = (state == ST_WAIT);
endmodule

// File: rtl/sram_dual.sv
// Simple dual-port SRAM: one write port and one read port, read data registered (1-cycle latency).
module sram_dual #(
    parameter int ADDR_W = 3,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_wr,
    input  logic [ADDR_W-1:0] addr_wr,
    input  logic [DW-1:0]     dat_wr,
    input  logic              en_rd,
    input  logic [ADDR_W-1:0] addr_rd,
    output logic [DW-1:0]     dat_rd
);
    logic [DW-1:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset; only the read register is cleared so outputs start at 0.
    always_ff @(posedge clk) begin
        if (en_wr) mem[addr_wr] <= dat_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dat_rd <= '0;
        else if (en_rd) dat_rd <= mem[addr_rd];
    end
endmodule

// File: rtl/peb_psum_router.sv
// PSUM SRAM router for a PE block: private banks, ping-pong output banks, pool drain and stall.
// Optional macro PEB_PSUM_CLR_EN: each pool read zeroes the drained word one cycle later.
module peb_psum_router
    import peb_psum_router_pkg::*;
#(
    parameter int NUM_PEC    = 3,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int LENPSUM    = DEF_LENPSUM,
    parameter int ADDR_W     = c_log_2(LENPSUM),
    parameter int DW         = PSUM_WIDTH * LENPSUM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      CTRLPEB_FrtBlk,
    input  logic                      CTRLPEB_FnhFrm,
    input  logic [NUM_PEC-1:0]        PECRAM_EnWr,
    input  logic [NUM_PEC*ADDR_W-1:0] PECRAM_AddrWr,
    input  logic [NUM_PEC*DW-1:0]     PECRAM_DatWr,
    input  logic [NUM_PEC-1:0]        PECRAM_EnRd,
    input  logic [NUM_PEC*ADDR_W-1:0] PECRAM_AddrRd,
    output logic [NUM_PEC*DW-1:0]     RAMPEC_DatRd,
    input  logic                      POOLPEB_EnRd,
    input  logic [ADDR_W-1:0]         POOLPEB_AddrRd,
    output logic [DW-1:0]             PEBPOOL_Dat,
    output logic                      PEBPOOL_Vld,
    input  logic                      POOLPEB_Done,
    output logic                      PEBCTRL_Stall,
    output logic                      PEBCTRL_Err
);
    localparam int NUM_BANK = NUM_PEC + 1;
    localparam int OUT0     = NUM_PEC - 1;
    localparam int OUT1     = NUM_PEC;

    logic [ADDR_W-1:0]   pec_addr_wr [NUM_PEC];
    logic [ADDR_W-1:0]   pec_addr_rd [NUM_PEC];
    logic [DW-1:0]       pec_dat_wr  [NUM_PEC];

    logic [NUM_BANK-1:0] bank_en_wr, bank_en_rd;
    logic [ADDR_W-1:0]   bank_addr_wr [NUM_BANK];
    logic [ADDR_W-1:0]   bank_addr_rd [NUM_BANK];
    logic [DW-1:0]       bank_dat_wr  [NUM_BANK];
    logic [DW-1:0]       bank_dat_rd  [NUM_BANK];

    logic                bank_sel, bank_sel_d, frt_d, pool_busy;
    logic                act_en_wr, act_en_rd;
    logic [ADDR_W-1:0]   act_addr_wr, act_addr_rd;
    logic [DW-1:0]       act_dat_wr, act_dat_rd;
    logic                clr_en;
    logic [ADDR_W-1:0]   clr_addr;

    peb_pingpong_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .fnh_frm   (CTRLPEB_FnhFrm),
        .done      (POOLPEB_Done),
        .bank_sel  (bank_sel),
        .pool_busy (pool_busy),
        .stall     (PEBCTRL_Stall),
        .err       (PEBCTRL_Err)
    );

    assign PEBPOOL_Vld = pool_busy;

    // Read-data routing must follow the select that was live when the read was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frt_d      <= 1'b0;
            bank_sel_d <= 1'b0;
        end else begin
            frt_d      <= CTRLPEB_FrtBlk;
            bank_sel_d <= bank_sel;
        end
    end

`ifdef PEB_PSUM_CLR_EN
    logic              clr_vld, clr_bank;
    logic [ADDR_W-1:0] clr_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_vld    <= 1'b0;
            clr_bank   <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            clr_vld    <= POOLPEB_EnRd;
            clr_bank   <= ~bank_sel;
            clr_addr_q <= POOLPEB_AddrRd;
        end
    end

    // Drop the clear if the bank swapped back to the array in between.
    assign clr_en   = clr_vld & (clr_bank != bank_sel);
    assign clr_addr = clr_addr_q;
`else
    assign clr_en   = 1'b0;
    assign clr_addr = '0;
`endif

    // In the first block the second-to-last PEC feeds the accumulating out bank; the last PEC is dropped.
    assign act_en_wr   = CTRLPEB_FrtBlk ? PECRAM_EnWr[NUM_PEC-2] : PECRAM_EnWr[NUM_PEC-1];
    assign act_addr_wr = CTRLPEB_FrtBlk ? pec_addr_wr[NUM_PEC-2] : pec_addr_wr[NUM_PEC-1];
    assign act_dat_wr  = CTRLPEB_FrtBlk ? pec_dat_wr[NUM_PEC-2]  : pec_dat_wr[NUM_PEC-1];
    assign act_en_rd   = CTRLPEB_FrtBlk ? PECRAM_EnRd[NUM_PEC-2] : PECRAM_EnRd[NUM_PEC-1];
    assign act_addr_rd = CTRLPEB_FrtBlk ? pec_addr_rd[NUM_PEC-2] : pec_addr_rd[NUM_PEC-1];

    assign bank_en_wr[OUT0]   = bank_sel ? clr_en         : act_en_wr;
    assign bank_addr_wr[OUT0] = bank_sel ? clr_addr       : act_addr_wr;
    assign bank_dat_wr[OUT0]  = bank_sel ? '0             : act_dat_wr;
    assign bank_en_rd[OUT0]   = bank_sel ? POOLPEB_EnRd   : act_en_rd;
    assign bank_addr_rd[OUT0] = bank_sel ? POOLPEB_AddrRd : act_addr_rd;

    assign bank_en_wr[OUT1]   = bank_sel ? act_en_wr      : clr_en;
    assign bank_addr_wr[OUT1] = bank_sel ? act_addr_wr    : clr_addr;
    assign bank_dat_wr[OUT1]  = bank_sel ? act_dat_wr     : '0;
    assign bank_en_rd[OUT1]   = bank_sel ? act_en_rd      : POOLPEB_EnRd;
    assign bank_addr_rd[OUT1] = bank_sel ? act_addr_rd    : POOLPEB_AddrRd;

    assign act_dat_rd  = bank_sel_d ? bank_dat_rd[OUT1] : bank_dat_rd[OUT0];
    assign PEBPOOL_Dat = bank_sel_d ? bank_dat_rd[OUT0] : bank_dat_rd[OUT1];

    for (genvar g = 0; g < NUM_PEC; g++) begin : g_pec
        assign pec_addr_wr[g] = PECRAM_AddrWr[g*ADDR_W +: ADDR_W];
        assign pec_addr_rd[g] = PECRAM_AddrRd[g*ADDR_W +: ADDR_W];
        assign pec_dat_wr[g]  = PECRAM_DatWr[g*DW +: DW];

        if (g < NUM_PEC - 1) begin : g_priv
            localparam int   PREV     = (g == 0) ? 0 : g - 1;
            localparam logic HAS_PREV = (g != 0);
            assign bank_en_wr[g]   = CTRLPEB_FrtBlk ? (HAS_PREV & PECRAM_EnWr[PREV]) : PECRAM_EnWr[g];
            assign bank_addr_wr[g] = CTRLPEB_FrtBlk ? pec_addr_wr[PREV] : pec_addr_wr[g];
            assign bank_dat_wr[g]  = CTRLPEB_FrtBlk ? pec_dat_wr[PREV]  : pec_dat_wr[g];
            assign bank_en_rd[g]   = CTRLPEB_FrtBlk ? (HAS_PREV & PECRAM_EnRd[PREV]) : PECRAM_EnRd[g];
            assign bank_addr_rd[g] = CTRLPEB_FrtBlk ? pec_addr_rd[PREV] : pec_addr_rd[g];
        end

        if (g == NUM_PEC - 1) begin : g_rd_last
            assign RAMPEC_DatRd[g*DW +: DW] = frt_d ? '0 : act_dat_rd;
        end else if (g == 0) begin : g_rd_first
            assign RAMPEC_DatRd[g*DW +: DW] = frt_d ? '0 : bank_dat_rd[0];
        end else if (g == NUM_PEC - 2) begin : g_rd_pre_last
            assign RAMPEC_DatRd[g*DW +: DW] = frt_d ? act_dat_rd : bank_dat_rd[g];
        end else begin : g_rd_mid
            assign RAMPEC_DatRd[g*DW +: DW] = frt_d ? bank_dat_rd[g+1] : bank_dat_rd[g];
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        sram_dual #(
            .ADDR_W (ADDR_W),
            .DW     (DW)
        ) u_sram (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_wr   (bank_en_wr[b]),
            .addr_wr (bank_addr_wr[b]),
            .dat_wr  (bank_dat_wr[b]),
            .en_rd   (bank_en_rd[b]),
            .addr_rd (bank_addr_rd[b]),
            .dat_rd  (bank_dat_rd[b])
        );
    end
endmodule

// File: tb/tb_peb_psum_router.sv
// Scoreboard bench for peb_psum_router: directed routing, masking, ping-pong, stall and error vectors.
module tb_peb_psum_router;
    import peb_psum_router_pkg::*;

    localparam int NUM_PEC = 3;
    localparam int ADDR_W  = c_log_2(DEF_LENPSUM);
    localparam int DW      = DEF_PSUM_WIDTH * DEF_LENPSUM;
    localparam int POOL    = NUM_PEC;

    typedef struct {
        int            port;
        logic [DW-1:0] value;
        string         name;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      frt, fnh, done, pool_en;
    logic [NUM_PEC-1:0]        en_wr, en_rd;
    logic [NUM_PEC*ADDR_W-1:0] addr_wr, addr_rd;
    logic [NUM_PEC*DW-1:0]     dat_wr;
    logic [ADDR_W-1:0]         pool_addr;
    logic [NUM_PEC*DW-1:0]     dat_rd;
    logic [DW-1:0]             pool_dat;
    logic                      vld, stall, err;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          fire     = 1'b0;
    logic [DW-1:0] clr_exp;

    always #5 clk = ~clk;

    peb_psum_router #(.NUM_PEC(NUM_PEC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .CTRLPEB_FrtBlk (frt),
        .CTRLPEB_FnhFrm (fnh),
        .PECRAM_EnWr    (en_wr),
        .PECRAM_AddrWr  (addr_wr),
        .PECRAM_DatWr   (dat_wr),
        .PECRAM_EnRd    (en_rd),
        .PECRAM_AddrRd  (addr_rd),
        .RAMPEC_DatRd   (dat_rd),
        .POOLPEB_EnRd   (pool_en),
        .POOLPEB_AddrRd (pool_addr),
        .PEBPOOL_Dat    (pool_dat),
        .PEBPOOL_Vld    (vld),
        .POOLPEB_Done   (done),
        .PEBCTRL_Stall  (stall),
        .PEBCTRL_Err    (err)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, DW'(act), DW'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        en_wr   = '0;
        en_rd   = '0;
        pool_en = 1'b0;
        fnh     = 1'b0;
        done    = 1'b0;
    endtask

    task automatic pec_write(input int p, input logic [ADDR_W-1:0] a, input logic [DW-1:0] d);
        en_wr[p]                   = 1'b1;
        addr_wr[p*ADDR_W +: ADDR_W] = a;
        dat_wr[p*DW +: DW]          = d;
    endtask

    task automatic pec_read(input int p, input logic [ADDR_W-1:0] a, input logic [DW-1:0] exp, input string name);
        en_rd[p]                   = 1'b1;
        addr_rd[p*ADDR_W +: ADDR_W] = a;
        sb.push_back('{p, exp, name});
    endtask

    task automatic pool_read(input logic [ADDR_W-1:0] a, input logic [DW-1:0] exp, input string name);
        pool_en   = 1'b1;
        pool_addr = a;
        sb.push_back('{POOL, exp, name});
    endtask

    // Any read enable sampled at an edge means one result is presented after that edge.
    always @(posedge clk) fire <= (|en_rd) | pool_en;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fire) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: read data presented with no expected entry");
                end else begin
                    e = sb.pop_front();
                    if (e.port == POOL) check(e.name, pool_dat, e.value);
                    else                check(e.name, dat_rd[e.port*DW +: DW], e.value);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef PEB_PSUM_CLR_EN
        clr_exp = '0;
`else
        clr_exp = DW'('h66);
`endif
        rst_n = 1'b0; frt = 1'b0; fnh = 1'b0; done = 1'b0; pool_en = 1'b0;
        en_wr = '0; en_rd = '0; addr_wr = '0; addr_rd = '0; dat_wr = '0; pool_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_vld", vld, 1'b0);
        check_bit("rst_stall", stall, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check("rst_pool_dat", pool_dat, '0);
        for (int i = 0; i < NUM_PEC; i++) check($sformatf("rst_pec%0d_dat", i), dat_rd[i*DW +: DW], '0);
        rst_n = 1'b1;
        step();

        // Normal routing: PEC1 owns bank 1.
        pec_write(1, 2, 'h5); step();
        pec_read(1, 2, 'h5, "t1_pec1_rd"); step();

        // First block: shifted routing, masked edge PECs, last PEC writes dropped.
        frt = 1'b1;
        pec_write(0, 1, 'h7); pec_read(0, 0, '0, "t2_pec0_mask"); step();
        pec_write(1, 0, 'hA); pec_write(2, 0, 'h9); pec_read(2, 0, '0, "t2_pec2_mask"); step();
        frt = 1'b0;
        pec_read(1, 1, 'h7, "t2_pec1_rd_shifted"); step();
        pec_read(2, 0, 'hA, "t2_pec2_write_dropped"); step();

        // Frame end with idle pool: swap to out bank 1, pool drains out bank 0.
        pec_write(2, 0, 'h33); step();
        pec_write(2, 3, 'h66); step();
        check_bit("t3_vld_before", vld, 1'b0);
        fnh = 1'b1; step();
        check_bit("t3_vld_after", vld, 1'b1);
        check_bit("t3_no_stall", stall, 1'b0);
        pool_read(0, 'h33, "t3_pool_a0"); step();
        pec_write(2, 1, 'h44); step();
        pec_read(2, 1, 'h44, "t3_pec2_new_bank"); step();
        pool_read(3, 'h66, "t6_pool_a3"); step();
        step(); step();
        pool_read(3, clr_exp, "t6_pool_a3_reread"); step();

        // Second frame end while the pool is busy: stall, then error on a third request.
        fnh = 1'b1;
        check_bit("t4_stall_not_comb", stall, 1'b0);
        step();
        check_bit("t4_stall_on", stall, 1'b1);
        step();
        fnh = 1'b1; step();
        check_bit("t5_err_set", err, 1'b1);
        step(); step();
        check_bit("t4_stall_held", stall, 1'b1);
        done = 1'b1; step();
        check_bit("t4_stall_off", stall, 1'b0);
        check_bit("t4_vld_kept", vld, 1'b1);
        check_bit("t5_err_sticky", err, 1'b1);
        pec_read(2, 3, clr_exp, "t4_pec2_back_on_bank0"); step();
        pool_read(1, 'h44, "t4_pool_bank1"); step();

        // Done in ACC releases the pool.
        done = 1'b1; step();
        check_bit("t4_vld_cleared", vld, 1'b0);
        check_bit("t5_err_still", err, 1'b1);
        step(); step();
        check("sb_drained", DW'(sb.size()), '0);

        rst_n = 1'b0;
        #1;
        check_bit("t5_err_reset", err, 1'b0);
        check_bit("rst2_vld", vld, 1'b0);
        check_bit("rst2_stall", stall, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
